block_rescale_restore: RTL and testbench
========================================

Name: block_rescale_restore

Overview:
- Inverse of block rescale/prepare: accepts a stream of block-floating-point elements (signed mantissa plus one shared 6-bit quant_bit per block) and re-normalizes each element to its own quant_bit.
- Each element is left-shifted to remove redundant sign bits, never pushing its exponent below -32.
- Sits at the output of dot-product/accumulate stages, ahead of per-element consumers.
- Two-stage valid/ready pipeline; also reports the minimum per-element quant_bit of each block.

Parameters:
- W, 16, mantissa width in bits (signed two's complement).
- CW, 10, element counter width; a block holds at most 2^CW elements.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_first  input  1  first element of block; block_quant_bit sampled on this beat
- in_last  input  1  last element of block
- in  input  W  signed mantissa
- block_quant_bit  input  6  signed shared exponent, range -32..31
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready
- out  output  W  normalized signed mantissa
- out_quant_bit  output  6  signed per-element exponent
- out_last  output  1  last element of block
- quant_bits_min  output  6  signed minimum out_quant_bit over the last completed block
- blk_len  output  CW  element count of the last completed block (0 encodes 2^CW)
- blk_done  output  1  one-cycle pulse when quant_bits_min and blk_len update
- proto_err  output  1  sticky; cleared only by reset

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - all pipeline valids = 0, out = 0, out_quant_bit = 0, out_last = 0.
  - quant_bits_min = 0, blk_len = 0, blk_done = 0, proto_err = 0.
  - Element counter = 0, in-block flag = 0.
  - Reset mid-block discards all in-flight data; no blk_done is emitted for that block.
- Handshake:
  - Stage enables: en2 = !v2 || out_ready; en1 = !v1 || en2; in_ready = en1.
  - Full throughput of 1 element/cycle. Latency is 2 cycles from accept to out_valid when out_ready is high.
  - out and its sideband stay stable while out_valid && !out_ready.
- Block tracking:
  - The exponent used on a beat is block_quant_bit when in_first = 1, else the exponent latched on the most recent in_first beat.
  - in_first && in_last on the same beat is a legal 1-element block.
  - Protocol errors (proto_err set, beat still processed):
    - in_first while already in a block: the new block starts.
    - Beat without in_first while not in a block: the block's latched exponent is used.
    - Counter wrap past 2^CW elements without in_last.
- Stage 1 (register):
  - Capture mantissa, exponent q, and last.
  - Compute cls = count of leading bits equal to the sign bit, minus 1; range 0..W-1.
  - For mantissa 0 or all-ones, cls = W-1.
- Stage 2 normalization (signed arithmetic, 7-bit intermediate for q - s):
  - Mantissa == 0: out = 0, out_quant_bit = -32.
  - Otherwise s = min(cls, q + 32).
  - out = mantissa << s, with no overflow by construction; out_quant_bit = q - s, always ≥ -32.
  - q = 31 with maximum positive mantissa (inf encoding) has cls = 0 and passes through unchanged.
  - Most negative mantissa has cls = 0 and is unchanged.
- Block statistics, updated on output handshake:
  - Running minimum is reset to out_quant_bit on the block's first output beat.
  - On the out_last handshake: quant_bits_min = final running minimum, blk_len = element count, blk_done pulses the next cycle.

Decomposition:
- Shared package, block floating point definitions:
  - QB_W = 6, QB_MIN = -32, QB_MAX = 31.
  - Signed quant_bit typedef.
- Sub-module cls_count #(W): combinational leading-sign counter, reused by other normalizers.

Test Plan:
- W=16, block of 3 with block_quant_bit = 0: in = 0x0001, 0x4000, 0x0000 -> out = 0x4000/qb -14; 0x4000/qb 0; 0x0000/qb -32. quant_bits_min = -32, blk_len = 3, blk_done one pulse.
- Exponent floor: block_quant_bit = -30, in = 0x0001 -> s = 2, out = 0x0004, out_quant_bit = -32. Also in = 0xFFFF at qb -30 -> out = 0xFFFC, qb -32.
- Inf passthrough: block_quant_bit = 31, in = 0x7FFF -> out = 0x7FFF, qb 31. Also in = 0x8000 -> out = 0x8000, qb 31.
- Backpressure: stream 8 elements with out_ready toggling 1,0,0,1,... -> no loss or duplication, order preserved, outputs stable while stalled, in_ready drops only when both stages are full.
- Protocol:
  - in_first mid-block -> proto_err = 1; the new block exponent is used from that beat.
  - Single-beat block (in_first && in_last) -> blk_len = 1, blk_done pulses.
- Reset mid-block: assert rst_n = 0 for one cycle after 2 of 4 elements -> out_valid = 0 next cycle, no blk_done, outputs at reset values; the next block processes normally.

Source files
------------

// File: rtl/block_rescale_restore_pkg.sv
// rtl/block_rescale_restore_pkg.sv - block floating point definitions
package block_rescale_restore_pkg;

   localparam int QB_W   = 6;
   localparam int QB_MIN = -32;
   localparam int QB_MAX = 31;

   typedef logic signed [QB_W-1:0] qb_t;

   function automatic qb_t qb_min(input qb_t a, input qb_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/block_rescale_restore_if.sv
// rtl/block_rescale_restore_if.sv - element stream in/out plus block statistics
interface block_rescale_restore_if #(
   parameter int W  = 16,
   parameter int CW = 10
);
   import block_rescale_restore_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic         in_first;
   logic         in_last;
   logic [W-1:0] in;
   qb_t          block_quant_bit;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   qb_t          out_quant_bit;
   logic         out_last;
   qb_t          quant_bits_min;
   logic [CW-1:0] blk_len;
   logic         blk_done;
   logic         proto_err;

   modport slave (
      input  in_valid, in_first, in_last, in, block_quant_bit, out_ready,
      output in_ready, out_valid, out, out_quant_bit, out_last,
             quant_bits_min, blk_len, blk_done, proto_err
   );

   modport master (
      output in_valid, in_first, in_last, in, block_quant_bit, out_ready,
      input  in_ready, out_valid, out, out_quant_bit, out_last,
             quant_bits_min, blk_len, blk_done, proto_err
   );
endinterface

// File: rtl/block_rescale_restore_cls_count.sv
// rtl/block_rescale_restore_cls_count.sv - leading sign bit count minus one
module cls_count #(
   parameter int W   = 16,
   parameter int CLW = $clog2(W)
) (
   input  logic [W-1:0]   m_i,
   output logic [CLW-1:0] cls_o
);

   logic run;

   // Counts bits below the sign that still match it; 0 and all-ones give W-1.
   always_comb begin
      cls_o = '0;
      run   = 1'b1;
      for (int i = W - 2; i >= 0; i--) begin
         if (run && (m_i[i] == m_i[W-1])) begin
            cls_o = cls_o + CLW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/block_rescale_restore.sv
// rtl/block_rescale_restore.sv - renormalize block floating point elements to per-element exponents
module block_rescale_restore
   import block_rescale_restore_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   block_rescale_restore_if.slave bus
);

   localparam int CLW  = $clog2(W);
   localparam int QS_W = QB_W + 1;

   logic          en1, en2, acc, ohs;
   logic          beat_first, beat_err;
   qb_t           beat_q;
   logic [CLW-1:0] cls_w;

   logic          in_blk_q;
   logic [CW-1:0] cnt_q;
   qb_t           qexp_q;
   logic          perr_q;

   logic          v1_q, last1_q, first1_q;
   logic [W-1:0]  m1_q;
   qb_t           q1_q;
   logic [CLW-1:0] cls1_q;

   logic          v2_q, last2_q, first2_q;
   logic [W-1:0]  out_q;
   qb_t           oqb_q;

   logic signed [QS_W-1:0] q_ext, head, cls_ext, s_amt, qs;
   logic [W-1:0]  norm_d;
   qb_t           nqb_d;

   qb_t           min_q, qmin_q, run_min_d;
   logic [CW-1:0] ocnt_q, blk_len_q, len_d;
   logic          done_q;

   assign en2 = !v2_q || bus.out_ready;
   assign en1 = !v1_q || en2;
   assign acc = bus.in_valid && en1;
   assign ohs = v2_q && bus.out_ready;

   // A beat arriving outside a block opens one, so stats restart cleanly.
   assign beat_first = bus.in_first || !in_blk_q;
   assign beat_q     = bus.in_first ? bus.block_quant_bit : qexp_q;
   assign beat_err   = (bus.in_first && in_blk_q) || (!bus.in_first && !in_blk_q) ||
                       (!beat_first && (cnt_q == '0));

   cls_count #(.W(W), .CLW(CLW)) u_cls (
      .m_i   (bus.in),
      .cls_o (cls_w)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_blk_q <= 1'b0;
         cnt_q    <= '0;
         qexp_q   <= '0;
         perr_q   <= 1'b0;
      end else if (acc) begin
         in_blk_q <= !bus.in_last;
         cnt_q    <= beat_first ? CW'(1) : cnt_q + CW'(1);
         if (bus.in_first) qexp_q <= bus.block_quant_bit;
         if (beat_err) perr_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         m1_q     <= '0;
         q1_q     <= '0;
         cls1_q   <= '0;
         last1_q  <= 1'b0;
         first1_q <= 1'b0;
      end else if (en1) begin
         v1_q <= bus.in_valid;
         if (bus.in_valid) begin
            m1_q     <= bus.in;
            q1_q     <= beat_q;
            cls1_q   <= cls_w;
            last1_q  <= bus.in_last;
            first1_q <= beat_first;
         end
      end
   end

   // Shift is capped by the headroom above the exponent floor.
   always_comb begin
      q_ext   = QS_W'(q1_q);
      head    = q_ext + QS_W'(32);
      cls_ext = signed'(QS_W'(cls1_q));
      s_amt   = (cls_ext < head) ? cls_ext : head;
      qs      = q_ext - s_amt;
      if (m1_q == '0) begin
         norm_d = '0;
         nqb_d  = qb_t'(QB_MIN);
      end else begin
         norm_d = m1_q << s_amt;
         nqb_d  = qs[QB_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_q     <= 1'b0;
         out_q    <= '0;
         oqb_q    <= '0;
         last2_q  <= 1'b0;
         first2_q <= 1'b0;
      end else if (en2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            out_q    <= norm_d;
            oqb_q    <= nqb_d;
            last2_q  <= last1_q;
            first2_q <= first1_q;
         end
      end
   end

   always_comb begin
      run_min_d = first2_q ? oqb_q : qb_min(min_q, oqb_q);
      len_d     = first2_q ? CW'(1) : ocnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min_q     <= '0;
         ocnt_q    <= '0;
         qmin_q    <= '0;
         blk_len_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= ohs && last2_q;
         if (ohs) begin
            min_q  <= run_min_d;
            ocnt_q <= len_d;
            if (last2_q) begin
               qmin_q    <= run_min_d;
               blk_len_q <= len_d;
            end
         end
      end
   end

   assign bus.in_ready       = en1;
   assign bus.out_valid      = v2_q;
   assign bus.out            = out_q;
   assign bus.out_quant_bit  = oqb_q;
   assign bus.out_last       = last2_q;
   assign bus.quant_bits_min = qmin_q;
   assign bus.blk_len        = blk_len_q;
   assign bus.blk_done       = done_q;
   assign bus.proto_err      = perr_q;

endmodule

// File: tb/tb_block_rescale_restore.sv
// tb/tb_block_rescale_restore.sv - directed self-checking bench for block_rescale_restore
module tb_block_rescale_restore;
   import block_rescale_restore_pkg::*;

   typedef struct {
      logic [15:0] d;
      qb_t         q;
      logic        l;
   } beat_t;

   typedef struct {
      qb_t        m;
      logic [9:0] n;
   } blk_t;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   beat_t obeats[$];
   blk_t  oblks[$];

   logic        p_stall = 1'b0;
   logic [15:0] p_out;
   qb_t         p_qb;
   logic        p_last;
   logic        saw_full = 1'b0;

   block_rescale_restore_if #(.W(16), .CW(10)) bus ();

   block_rescale_restore #(.W(16), .CW(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && p_stall) begin
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_out", bus.out, p_out);
         chk("stall_qb", bus.out_quant_bit, p_qb);
         chk("stall_last", bus.out_last, p_last);
      end
      p_stall = rst_n && bus.out_valid && !bus.out_ready;
      p_out   = bus.out;
      p_qb    = bus.out_quant_bit;
      p_last  = bus.out_last;
      if (rst_n && (bus.out_ready || !bus.out_valid)) chk("in_ready_open", bus.in_ready, 1);
      if (rst_n && !bus.in_ready) saw_full = 1'b1;
      if (rst_n && bus.out_valid && bus.out_ready)
         obeats.push_back('{d: bus.out, q: bus.out_quant_bit, l: bus.out_last});
      if (rst_n && bus.blk_done)
         oblks.push_back('{m: bus.quant_bits_min, n: bus.blk_len});
   end

   task automatic send(input logic f, input logic l, input logic [15:0] d, input int q);
      logic got;
      got                 = 1'b0;
      bus.in_valid        = 1'b1;
      bus.in_first        = f;
      bus.in_last         = l;
      bus.in              = d;
      bus.block_quant_bit = qb_t'(q);
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = bus.in_ready;
      end
      chk("in_accept", got, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input string tag, input logic [15:0] d, input int q, input logic l);
      beat_t b;
      chk({tag, "_present"}, (obeats.size() != 0), 1);
      if (obeats.size() != 0) begin
         b = obeats.pop_front();
         chk({tag, "_out"}, b.d, d);
         chk({tag, "_qb"}, b.q, q);
         chk({tag, "_last"}, b.l, l);
      end
   endtask

   task automatic expect_blk(input string tag, input int m, input int n);
      blk_t b;
      chk({tag, "_nblk"}, oblks.size(), 1);
      chk({tag, "_nbeats_left"}, obeats.size(), 0);
      if (oblks.size() != 0) begin
         b = oblks.pop_front();
         chk({tag, "_qmin"}, b.m, m);
         chk({tag, "_len"}, b.n, n);
      end
      oblks.delete();
   endtask

   initial begin
      logic [15:0] bp_in  [8] = '{16'h0003, 16'h0050, 16'h1234, 16'hFF80,
                                  16'h7000, 16'h0007, 16'hFFFE, 16'h2001};
      logic [15:0] bp_out [8] = '{16'h6000, 16'h5000, 16'h48D0, 16'h8000,
                                  16'h7000, 16'h7000, 16'h8000, 16'h4002};
      int          bp_qb  [8] = '{-13, -8, -2, -8, 0, -12, -14, -1};

      rst_n               = 1'b0;
      bus.in_valid        = 1'b0;
      bus.in_first        = 1'b0;
      bus.in_last         = 1'b0;
      bus.in              = '0;
      bus.block_quant_bit = '0;
      bus.out_ready       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_out_qb", bus.out_quant_bit, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_qmin", bus.quant_bits_min, 0);
      chk("rst_blk_len", bus.blk_len, 0);
      chk("rst_blk_done", bus.blk_done, 0);
      chk("rst_perr", bus.proto_err, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;

      // Basic block of three at exponent 0, with latency probe
      send(1, 0, 16'h0001, 0);
      chk("lat_v0", bus.out_valid, 0);
      send(0, 0, 16'h4000, 0);
      chk("lat_v1", bus.out_valid, 1);
      send(0, 1, 16'h0000, 0);
      idle(6);
      expect_beat("b1e0", 16'h4000, -14, 0);
      expect_beat("b1e1", 16'h4000, 0, 0);
      expect_beat("b1e2", 16'h0000, -32, 1);
      expect_blk("b1", -32, 3);
      chk("b1_perr", bus.proto_err, 0);

      // Exponent floor
      send(1, 0, 16'h0001, -30);
      send(0, 1, 16'hFFFF, 0);
      idle(5);
      expect_beat("floor0", 16'h0004, -32, 0);
      expect_beat("floor1", 16'hFFFC, -32, 1);
      expect_blk("floor", -32, 2);

      // Inf and most-negative passthrough at exponent 31
      send(1, 0, 16'h7FFF, 31);
      send(0, 1, 16'h8000, 0);
      idle(5);
      expect_beat("inf0", 16'h7FFF, 31, 0);
      expect_beat("inf1", 16'h8000, 31, 1);
      expect_blk("inf", 31, 2);

      // Backpressure: out_ready pattern 1,0,0 repeating
      saw_full = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(i == 0, i == 7, bp_in[i], 0);
         end
         begin
            for (int c = 0; c < 300 && obeats.size() < 8; c++) begin
               bus.out_ready = (c % 3 == 0);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      idle(4);
      for (int i = 0; i < 8; i++) expect_beat($sformatf("bp%0d", i), bp_out[i], bp_qb[i], i == 7);
      expect_blk("bp", -14, 8);
      chk("bp_full_seen", saw_full, 1);
      chk("bp_perr", bus.proto_err, 0);

      // in_first mid-block: new block and exponent take over
      send(1, 0, 16'h4000, 5);
      send(1, 0, 16'h0001, -3);
      send(0, 1, 16'h0002, 0);
      idle(5);
      expect_beat("pe0", 16'h4000, 5, 0);
      expect_beat("pe1", 16'h4000, -17, 0);
      expect_beat("pe2", 16'h4000, -16, 1);
      expect_blk("pe", -17, 2);
      chk("pe_perr", bus.proto_err, 1);

      // Single-beat block
      send(1, 1, 16'h0000, 10);
      idle(5);
      expect_beat("one", 16'h0000, -32, 1);
      expect_blk("one", -32, 1);

      // Reset mid-block after 2 of 4 elements
      send(1, 0, 16'h1111, 4);
      send(0, 0, 16'h2222, 4);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_valid", bus.out_valid, 0);
      chk("mrst_out", bus.out, 0);
      chk("mrst_qb", bus.out_quant_bit, 0);
      chk("mrst_last", bus.out_last, 0);
      chk("mrst_perr", bus.proto_err, 0);
      chk("mrst_qmin", bus.quant_bits_min, 0);
      chk("mrst_len", bus.blk_len, 0);
      rst_n = 1'b1;
      idle(4);
      chk("mrst_noblk", oblks.size(), 0);
      chk("mrst_idle_valid", bus.out_valid, 0);
      obeats.delete();
      send(1, 0, 16'h0001, 2);
      send(0, 1, 16'h0100, 2);
      idle(5);
      expect_beat("post0", 16'h4000, -12, 0);
      expect_beat("post1", 16'h4000, -4, 1);
      expect_blk("post", -12, 2);
      chk("post_perr", bus.proto_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
